// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT load controller: FSM state encoding,
// error-flag bit positions and default parameter values.
package gat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } gat_state_t;

    localparam int unsigned ERR_MISALIGN = 0;
    localparam int unsigned ERR_BUSY     = 1;
    localparam int unsigned ERR_TIMEOUT  = 2;

    localparam int unsigned GAT_NUM_CH    = 3;
    localparam int unsigned GAT_ADDR_W    = 18;
    localparam int unsigned GAT_DATA_W    = 21;
    localparam int unsigned GAT_CNT_W     = 20;
    localparam int unsigned GAT_TIMEOUT_W = 24;

endpackage

// File: rtl/gat_load_chan.sv
// One BRAM load channel: registers an accepted host write as a word-addressed,
// width-trimmed BRAM write and counts accepted writes (saturating).
module gat_load_chan
    import gat_pkg::*;
#(
    parameter int unsigned ADDR_W = GAT_ADDR_W,
    parameter int unsigned DATA_W = GAT_DATA_W,
    parameter int unsigned CNT_W  = GAT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              clear,
    input  logic [31:0]       din,
    input  logic [ADDR_W+1:0] addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [CNT_W-1:0]  wr_cnt
);

    // Upper data bits and the byte offset are intentionally discarded here.
    logic unused_in;
    assign unused_in = ^{din, addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            wr_cnt    <= '0;
        end else begin
            bram_we <= accept;
            if (accept) begin
                bram_addr <= addr[ADDR_W+1:2];
                bram_din  <= din[DATA_W-1:0];
            end
            if (clear) begin
                wr_cnt <= '0;
            end else if (accept && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gat_load_ctrl.sv
// GAT load controller: gates host BRAM loads per channel, sequences core start/run/done.
// Optional watchdog on the RUN state enabled by defining GAT_LOAD_TIMEOUT_EN.
module gat_load_ctrl
    import gat_pkg::*;
#(
    parameter int unsigned NUM_CH    = GAT_NUM_CH,
    parameter int unsigned ADDR_W    = GAT_ADDR_W,
    parameter int unsigned DATA_W    = GAT_DATA_W,
    parameter int unsigned CNT_W     = GAT_CNT_W,
    parameter int unsigned TIMEOUT_W = GAT_TIMEOUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*32-1:0]       ld_din,
    input  logic [NUM_CH-1:0]          ld_en,
    input  logic [NUM_CH-1:0]          ld_we,
    input  logic [NUM_CH*(ADDR_W+2)-1:0] ld_addr,
    input  logic [NUM_CH-1:0]          ld_done,
    input  logic                       gat_layer,
    input  logic                       core_done,
    output logic [NUM_CH*DATA_W-1:0]   bram_din,
    output logic [NUM_CH-1:0]          bram_we,
    output logic [NUM_CH*ADDR_W-1:0]   bram_addr,
    output logic                       core_start,
    output logic                       core_layer,
    output logic                       gat_ready,
    output logic [NUM_CH*CNT_W-1:0]    wr_cnt,
    output logic [2:0]                 err
);

    gat_state_t        state;
    logic [NUM_CH-1:0] done_lat;
    logic [NUM_CH-1:0] done_prev;
    logic [NUM_CH-1:0] done_rise;
    logic [NUM_CH-1:0] wr_req;
    logic [NUM_CH-1:0] misalign;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] busy_wr;
    logic              load_ok;
    logic              busy;
    logic              clr;
    logic              timeout_hit;

    assign load_ok = (state == ST_IDLE) || (state == ST_LOAD);
    assign busy    = (state == ST_RUN) || (state == ST_DONE);
    assign clr     = (state == ST_DONE) && (ld_done == '0);
    assign wr_req  = ld_en & ld_we;
    // done_prev is held at zero outside LOAD, so bits already high on entry read as rising.
    assign done_rise = ld_done & ~done_prev;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        assign misalign[c] = wr_req[c] && (ld_addr[c*(ADDR_W+2) +: 2] != 2'b00);
        assign accept[c]   = wr_req[c] && !misalign[c] && load_ok;
        assign busy_wr[c]  = wr_req[c] && busy;

        gat_load_chan #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .accept    (accept[c]),
            .clear     (clr),
            .din       (ld_din[c*32 +: 32]),
            .addr      (ld_addr[c*(ADDR_W+2) +: ADDR_W+2]),
            .bram_din  (bram_din[c*DATA_W +: DATA_W]),
            .bram_we   (bram_we[c]),
            .bram_addr (bram_addr[c*ADDR_W +: ADDR_W]),
            .wr_cnt    (wr_cnt[c*CNT_W +: CNT_W])
        );
    end

`ifdef GAT_LOAD_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = WDOG_MAX - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] wdog;

    // Expiry fires on the edge where the watchdog reaches its all-ones value.
    assign timeout_hit = (state == ST_RUN) && (wdog == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (state == ST_START) begin
            wdog <= '0;
        end else if ((state == ST_RUN) && (wdog != WDOG_MAX)) begin
            wdog <= wdog + TIMEOUT_W'(1);
        end
    end
`else
    logic [TIMEOUT_W-1:0] unused_wdog;
    assign unused_wdog = '0;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            core_start <= 1'b0;
            core_layer <= 1'b0;
            gat_ready  <= 1'b0;
            err        <= '0;
            done_lat   <= '0;
            done_prev  <= '0;
        end else begin
            core_start <= 1'b0;
            done_prev  <= (state == ST_LOAD) ? ld_done : '0;
            err[ERR_MISALIGN] <= err[ERR_MISALIGN] | (|misalign);
            err[ERR_BUSY]     <= err[ERR_BUSY] | (|busy_wr);
            err[ERR_TIMEOUT]  <= err[ERR_TIMEOUT] | (timeout_hit & ~core_done);
            case (state)
                ST_IDLE: begin
                    done_lat <= done_lat | done_rise;
                    if ((|accept) || (|ld_done)) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    done_lat <= done_lat | done_rise;
                    if (&(done_lat | done_rise)) begin
                        state      <= ST_START;
                        core_start <= 1'b1;
                    end
                end
                ST_START: begin
                    core_layer <= gat_layer;
                    state      <= ST_RUN;
                end
                ST_RUN: begin
                    if (core_done || timeout_hit) begin
                        state     <= ST_DONE;
                        gat_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ld_done == '0) begin
                        state     <= ST_IDLE;
                        gat_ready <= 1'b0;
                        done_lat  <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gat_load_ctrl.md
GAT_LOAD_CTRL -- requirements
Module: gat_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent BRAM load channels.
REQ-002 SHALL have parameter ADDR_W, default 18: internal word-address width per channel.
REQ-003 SHALL have parameter DATA_W, default 21: internal data width per channel, at most 32.
REQ-004 SHALL have parameter CNT_W, default 20: per-channel write-counter width.
REQ-005 SHALL have parameter TIMEOUT_W, default 24: watchdog width, used only when GAT_LOAD_TIMEOUT_EN is defined.
REQ-006 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; every register is rising-edge.
- rst  in  1  synchronous, active-high reset.
- ld_din  in  NUM_CH*32  host write data, channel c at bits [32c+31:32c].
- ld_en  in  NUM_CH  host port enable.
- ld_we  in  NUM_CH  host write enable.
- ld_addr  in  NUM_CH*(ADDR_W+2)  host byte address.
- ld_done  in  NUM_CH  register-bank load-done level.
- gat_layer  in  1  requested layer.
- core_done  in  1  one-cycle completion pulse from the core.
- bram_din  out  NUM_CH*DATA_W  internal write data.
- bram_we  out  NUM_CH  internal write strobe.
- bram_addr  out  NUM_CH*ADDR_W  internal word address.
- core_start  out  1  one-cycle start pulse to the core.
- core_layer  out  1  layer latched at start.
- gat_ready  out  1  run complete.
- wr_cnt  out  NUM_CH*CNT_W  accepted writes per channel.
- err  out  3  sticky flags: [0] misaligned, [1] write while busy, [2] timeout.

Function
REQ-007 A host write on channel c SHALL be ld_en[c]&ld_we[c]; it is accepted only in IDLE or LOAD with ld_addr[1:0]==0.
REQ-008 An accepted write SHALL appear one cycle later on the outputs:
- bram_we[c]=1
- bram_addr = ld_addr[ADDR_W+1:2]
- bram_din = ld_din[DATA_W-1:0] (upper bits discarded)
REQ-009 A write with a non-zero ld_addr[1:0] SHALL be dropped (no bram_we) and SHALL set err[0].
REQ-010 A write in RUN or DONE SHALL be dropped and SHALL set err[1].
REQ-011 wr_cnt[c] SHALL increment on each accepted write and saturate at 2^CNT_W-1.
REQ-012 The FSM SHALL have states IDLE, LOAD, START, RUN and DONE.
REQ-013 IDLE SHALL go to LOAD on any accepted write or any ld_done bit high.
REQ-014 In LOAD, the per-channel done latch SHALL set on a rising edge of ld_done[c]; ld_done bits already high on entry to LOAD count as rising.
REQ-015 LOAD SHALL go to START in the cycle after all NUM_CH done latches are set.
REQ-016 START SHALL last exactly one cycle:
- core_start=1
- core_layer captures gat_layer
- next state is RUN
REQ-017 RUN SHALL go to DONE on core_done; a core_done in any other state SHALL be ignored.
REQ-018 In DONE, gat_ready SHALL be 1.
REQ-019 DONE SHALL go to IDLE once ld_done==0 on all channels; on that transition the done latches and wr_cnt clear, and err is kept.
REQ-020 A write and a rising ld_done on the same channel in the same cycle SHALL both take effect.
REQ-021 err SHALL clear only on rst.

Reset
REQ-022 rst SHALL force, on the next edge:
- state IDLE
- all outputs 0, including bram_*, core_start, core_layer, gat_ready, wr_cnt and err
- done latches 0
- watchdog 0
REQ-023 rst asserted mid-RUN SHALL abort without a core_start or gat_ready pulse.

Configuration
REQ-024 With GAT_LOAD_TIMEOUT_EN defined:
- a TIMEOUT_W-bit watchdog clears in START and counts in RUN.
- at 2^TIMEOUT_W-1 the FSM goes to DONE and sets err[2].
- core_done in the same cycle as expiry counts as normal completion and leaves err[2] clear.
REQ-025 Without GAT_LOAD_TIMEOUT_EN, there SHALL be no watchdog logic and err[2] SHALL be tied to 0.

Structure
REQ-026 Package gat_pkg SHALL hold the FSM state enum, the err bit indices and the default parameter constants.
REQ-027 The per-channel address/data translation plus counter SHALL be sub-module gat_load_chan, instantiated NUM_CH times by a generate loop; the FSM stays in the top level.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Channel 0 write, addr 0x10, data 0xFFFF_FFFF -> next cycle bram_addr[0]=4, bram_din=0x1F_FFFF, wr_cnt[0]=1.
- Write with addr 0x13 -> no bram_we, err[0]=1 sticky.
- Raise ld_done 1, 0, 2 on separate cycles -> a single core_start one cycle after the last; core_layer = gat_layer at START.
- Write during RUN -> dropped, err[1]=1; then core_done -> gat_ready=1; drop all ld_done -> IDLE, wr_cnt=0, err still set.
- With GAT_LOAD_TIMEOUT_EN and TIMEOUT_W=4, no core_done -> DONE 15 cycles after RUN entry, err[2]=1.
- rst during RUN -> all outputs 0 the next cycle, state IDLE.
